// File: rtl/scariv_csu_issue_unit.sv
// scariv_csu_issue_unit: in-order serializing issue buffer for the CSU pipe; define SCARIV_CSU_ISSUE_PERF_EN to add issue/wait perf counters
package scariv_csu_pkg;
   localparam int DISP_SIZE = 2;
   localparam int CMT_ID_W = 6;
   localparam int RNID_W = 7;
   typedef struct packed {
      logic              valid;
      logic              ready;
      logic [RNID_W-1:0] rnid;
   } reg_t;
   typedef struct packed {
      logic                 valid;
      logic [31:0]          inst;
      logic [CMT_ID_W-1:0]  cmt_id;
      logic [DISP_SIZE-1:0] grp_id;
      reg_t [1:0]           rd_regs;
   } issue_t;
endpackage

module scariv_csu_issue_unit
   import scariv_csu_pkg::*;
#(
   parameter int ENTRY_SIZE = 4
)(
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_disp_valid,
   input  issue_t               i_disp_entry,
   output logic                 o_disp_ready,
   input  logic [CMT_ID_W-1:0]  i_cmt_head_id,
   input  logic [DISP_SIZE-1:0] i_cmt_head_grp_id,
   input  logic                 i_wake_valid,
   input  logic [RNID_W-1:0]    i_wake_rnid,
   input  logic                 i_flush_valid,
   output issue_t               o_issue,
   input  logic                 i_done_valid,
   output logic                 o_busy
`ifdef SCARIV_CSU_ISSUE_PERF_EN
   ,
   output logic [31:0]          o_perf_issue_cnt,
   output logic [31:0]          o_perf_wait_cnt
`endif
);
   localparam int PW = $clog2(ENTRY_SIZE);
   typedef enum logic {IDLE, WAIT_DONE} state_t;
   state_t              state, state_nxt;
   issue_t              mem [ENTRY_SIZE];
   logic [ENTRY_SIZE-1:0] rdy;
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [PW:0]         count;
   issue_t              head;
   logic                head_rdy, issue_ok, push, disp_wake;

   assign head         = mem[rd_ptr];
   assign head_rdy     = rdy[rd_ptr] | (i_wake_valid & head.rd_regs[0].valid & (head.rd_regs[0].rnid == i_wake_rnid));
   assign issue_ok     = (state == IDLE) & (count != '0) & head_rdy & (head.cmt_id == i_cmt_head_id) &
                         (head.grp_id == i_cmt_head_grp_id) & !i_flush_valid;
   assign o_disp_ready = !count[PW];
   assign push         = i_disp_valid & o_disp_ready & !i_flush_valid;
   assign disp_wake    = i_wake_valid & (i_disp_entry.rd_regs[0].rnid == i_wake_rnid);
   assign o_busy       = (count != '0) | (state != IDLE);

   // state register
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) state <= IDLE;
      else            state <= state_nxt;
   end

   // next state: flush dominates, then issue, then the done report
   always_comb begin
      state_nxt = i_flush_valid ? IDLE :
                  issue_ok ? WAIT_DONE :
                  (state == WAIT_DONE && i_done_valid) ? IDLE : state;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge i_clk) begin
      if (!i_reset_n || i_flush_valid) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)     wr_ptr <= wr_ptr + 1'b1;
         if (issue_ok) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(push) - (PW+1)'(issue_ok);
      end
   end

   // entry storage; stale slots may also be woken, harmless since a push rewrites rdy
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < ENTRY_SIZE; i++)
         if (i_wake_valid & mem[i].rd_regs[0].valid & (mem[i].rd_regs[0].rnid == i_wake_rnid)) rdy[i] <= 1'b1;
      if (push) begin
         mem[wr_ptr] <= i_disp_entry;
         rdy[wr_ptr] <= !i_disp_entry.rd_regs[0].valid | i_disp_entry.rd_regs[0].ready | disp_wake;
      end
   end

   // issue register: valid is a one-cycle pulse per issued op
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) o_issue <= '0;
      else if (issue_ok) begin
         o_issue       <= head;
         o_issue.valid <= 1'b1;
      end else o_issue.valid <= 1'b0;
   end

`ifdef SCARIV_CSU_ISSUE_PERF_EN
   // saturating perf counters, untouched by flush
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         o_perf_issue_cnt <= '0;
         o_perf_wait_cnt  <= '0;
      end else begin
         if (issue_ok && o_perf_issue_cnt != '1) o_perf_issue_cnt <= o_perf_issue_cnt + 1'b1;
         if (count != '0 && state == IDLE && !issue_ok && o_perf_wait_cnt != '1) o_perf_wait_cnt <= o_perf_wait_cnt + 1'b1;
      end
   end
`endif
endmodule

// File: doc/scariv_csu_issue_unit.md
# scariv_csu_issue_unit

In-order issue buffer that feeds the CSU pipe (the `rv0_issue` input of `scariv_csu_pipe`). CSR, xRET, ECALL/EBREAK and VSETVL instructions are serializing. This block therefore holds them in a FIFO and issues the head entry only when all of the following hold:
- it is the oldest uncommitted instruction;
- its rs1 operand is ready;
- no previously issued CSU op is still in flight.

It releases the next op only after the pipe's done report for the current one.

## Interface
Parameters:
- ENTRY_SIZE, 4, FIFO depth; power of two, ≥2.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_reset_n  in  1  reset, synchronous, active-low.
- i_disp_valid  in  1  dispatch request.
- i_disp_entry  in  scariv_csu_pkg::issue_t  dispatched instruction.
- o_disp_ready  out  1  high when count < ENTRY_SIZE.
- i_cmt_head_id  in  $bits(issue_t.cmt_id)  cmt_id of the oldest uncommitted instruction.
- i_cmt_head_grp_id  in  DISP_SIZE  grp_id of the oldest uncommitted instruction.
- i_wake_valid  in  1  physical-register write wakeup.
- i_wake_rnid  in  $bits(issue_t.rd_regs[0].rnid)  wakeup register id.
- i_flush_valid  in  1  commit-time pipeline flush.
- o_issue  out  scariv_csu_pkg::issue_t  registered issue to the CSU pipe.
- i_done_valid  in  1  done report from CSU pipe ex3.
- o_busy  out  1  FIFO non-empty or state != IDLE.

## Operation
- Storage and pointers:
  - FIFO entries hold issue_t plus a rs1_ready bit.
  - wr_ptr/rd_ptr are log2(ENTRY_SIZE) bits, wrap modulo ENTRY_SIZE.
  - count is log2(ENTRY_SIZE)+1 bits.
- Dispatch: push when i_disp_valid & o_disp_ready & !i_flush_valid. The entry's rs1_ready is set to 1 if any of these holds:
  - rd_regs[0].valid=0;
  - rd_regs[0].ready=1;
  - i_wake_valid with i_wake_rnid == rd_regs[0].rnid in the same cycle.
- Dispatch while o_disp_ready=0 is ignored and leaves no state change.
- Wakeup: every valid entry whose rd_regs[0].rnid == i_wake_rnid with rd_regs[0].valid sets rs1_ready.
- State machine, IDLE / WAIT_DONE:
  - IDLE→WAIT_DONE when issue_ok. issue_ok = count≠0 & head.rs1_ready & head.cmt_id==i_cmt_head_id & head.grp_id==i_cmt_head_grp_id & !i_flush_valid.
  - On issue_ok: pop the head and load the o_issue register with the head entry, valid=1.
  - WAIT_DONE→IDLE on i_done_valid.
  - i_done_valid while in IDLE is ignored.
- o_issue.valid is high exactly one cycle per issue; it clears to 0 on the following edge.
- Flush (highest priority):
  - clears all entries, pointers, count and o_issue.valid;
  - forces IDLE;
  - drops a same-cycle dispatch;
  - an i_done_valid in the same cycle has no extra effect.
- Push and pop in the same cycle: count unchanged, both pointers advance.

## Timing
- Reset values: o_issue = 'h0, o_disp_ready=1, o_busy=0, state IDLE, count 0, pointers 0.
- Dispatch at cycle N (head, operands ready, cmt head matches): o_issue.valid high at N+2.
  - N: write.
  - N+1: issue_ok evaluated, o_issue register loads.
- The pipe reports done 3 cycles after o_issue.valid (at N+5).
- IDLE is entered on that edge. The next queued op can be valid at N+7 at the earliest.
- o_disp_ready depends only on the registered count, with no combinational path from i_disp_valid.
- The wakeup-to-issue path is combinational within the cycle. A wake in cycle M allows o_issue.valid at M+1.

## Configuration
- SCARIV_CSU_ISSUE_PERF_EN defined:
  - adds outputs o_perf_issue_cnt (32b, +1 per issue) and o_perf_wait_cnt (32b, +1 per cycle with count≠0 & state IDLE & !issue_ok);
  - both reset to 0, saturate at 'hFFFF_FFFF, and are not cleared by flush.
- Not defined: these ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- Single op: dispatch CSRRW with rs1 ready, cmt head matching at N → o_issue.valid at N+2 only; i_done_valid at N+5 → o_busy=0 at N+6.
- Serialization: dispatch 2 ready ops back-to-back with cmt head advancing → second o_issue.valid no earlier than 1 cycle after the first done, never overlapping.
- Wakeup: head rs1 not ready (rnid 0x12), i_wake_valid rnid 0x12 at cycle M → o_issue.valid at M+1; a wake on rnid 0x13 → no issue.
- Full: 4 dispatches with i_cmt_head_id mismatched → o_disp_ready=0; a 5th dispatch ignored; after head matches and 1 issues, o_disp_ready=1 next cycle.
- Flush: 3 entries queued plus one op in WAIT_DONE, i_flush_valid with a same-cycle dispatch → next cycle count 0, o_busy=0, o_issue.valid=0; a later done is ignored.
- Reset mid-operation: i_reset_n low for 1 cycle while in WAIT_DONE with 2 entries → all outputs at reset values next cycle; with PERF_EN the counters read 0.
